// File: rtl/turfio_pkg.sv
// Shared constants and types for the TURFIO CIN merge path.
package turfio_pkg;

  localparam logic [31:0] CIN_TRAIN_VALUE = 32'hA55A6996;
  localparam int          CIN_NUM_LANE    = 7;
  localparam int          CIN_TUSER_W     = 3;

  typedef logic [31:0] cin_word_t;

  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turfio_lane_fifo.sv
// Per-lane word FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate count.
module turfio_lane_fifo
  import turfio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      write,
  input  cin_word_t wr_data,
  input  logic      read,
  output cin_word_t rd_data,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cin_word_t   mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (read && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (write && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/turfio_cin_merge.sv
// Merges the CIN lanes of one port into a single stream: per-lane FIFOs,
// round-robin arbiter, one-word output register and sticky overflow flags.
module turfio_cin_merge
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_VALUE = CIN_TRAIN_VALUE,
  parameter int          NUM_LANE    = CIN_NUM_LANE,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [32*NUM_LANE-1:0] cin_command_i,
  input  logic [NUM_LANE-1:0]   cin_valid_i,
  input  logic [NUM_LANE-1:0]   lane_enable_i,
  input  logic                  drop_train_i,
  output logic [31:0]           m_tdata_o,
  output logic [2:0]            m_tuser_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [NUM_LANE-1:0]   overflow_o,
  input  logic                  overflow_clr_i
);

  localparam int LANE_W = lane_bits(NUM_LANE);

  logic [NUM_LANE-1:0] qual;
  logic [NUM_LANE-1:0] fifo_wr;
  logic [NUM_LANE-1:0] fifo_rd;
  logic [NUM_LANE-1:0] fifo_empty;
  logic [NUM_LANE-1:0] fifo_full;
  cin_word_t           fifo_dout [NUM_LANE];

  logic [LANE_W-1:0] rr;
  logic [LANE_W-1:0] rr_next;
  logic [LANE_W-1:0] grant_idx;
  logic              grant_vld;
  logic              load_ok;

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    assign qual[k] = cin_valid_i[k] & lane_enable_i[k]
                   & ~(drop_train_i & (cin_command_i[32*k +: 32] == TRAIN_VALUE));
    // Full is judged on the pre-edge state: a same-cycle read does not make room.
    assign fifo_wr[k] = qual[k] & ~fifo_full[k];
    assign fifo_rd[k] = grant_vld && (grant_idx == LANE_W'(k));

    turfio_lane_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .write   (fifo_wr[k]),
      .wr_data (cin_command_i[32*k +: 32]),
      .read    (fifo_rd[k]),
      .rd_data (fifo_dout[k]),
      .empty   (fifo_empty[k]),
      .full    (fifo_full[k])
    );
  end

  assign load_ok = !m_tvalid_o || m_tready_i;

  always_comb begin
    int                cand;
    logic [LANE_W-1:0] lane;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    lane      = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      cand = int'(rr) + i;
      if (cand >= NUM_LANE) cand = cand - NUM_LANE;
      lane = cand[LANE_W-1:0];
      if (load_ok && !grant_vld && !fifo_empty[lane]) begin
        grant_vld = 1'b1;
        grant_idx = lane;
      end
    end
  end

  assign rr_next = (grant_idx == LANE_W'(NUM_LANE-1)) ? '0 : grant_idx + LANE_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr         <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= '0;
      overflow_o <= '0;
    end else begin
      if (grant_vld) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= fifo_dout[grant_idx];
        m_tuser_o  <= 3'(grant_idx);
        rr         <= rr_next;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end
      // A fresh overflow outranks a coincident clear.
      overflow_o <= (overflow_o & ~{NUM_LANE{overflow_clr_i}}) | (qual & fifo_full);
    end
  end

endmodule

// File: tb/tb_turfio_cin_merge.sv
// Scoreboard bench for turfio_cin_merge: queue-based reference model plus
// directed scenarios and a randomized soak.
module tb_turfio_cin_merge;

  localparam int          NL    = 7;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TRAIN = 32'hA55A6996;

  logic              clk = 1'b0;
  logic              rst;
  logic [32*NL-1:0]  cin_command;
  logic [NL-1:0]     cin_valid;
  logic [NL-1:0]     lane_enable;
  logic              drop_train;
  logic [31:0]       m_tdata;
  logic [2:0]        m_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [NL-1:0]     overflow;
  logic              overflow_clr;

  turfio_cin_merge #(
    .TRAIN_VALUE (TRAIN),
    .NUM_LANE    (NL),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cin_command_i  (cin_command),
    .cin_valid_i    (cin_valid),
    .lane_enable_i  (lane_enable),
    .drop_train_i   (drop_train),
    .m_tdata_o      (m_tdata),
    .m_tuser_o      (m_tuser),
    .m_tvalid_o     (m_tvalid),
    .m_tready_i     (m_tready),
    .overflow_o     (overflow),
    .overflow_clr_i (overflow_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef logic [31:0] word_q_t[$];
  word_q_t     mq [NL];
  logic        m_vld  = 1'b0;
  logic [31:0] m_word = '0;
  logic [2:0]  m_lane = '0;
  int          m_rr   = 0;
  logic [NL-1:0] m_ovf = '0;
  logic [34:0] sb[$];

  logic [31:0] fired_words[$];
  logic [2:0]  fired_lanes[$];
  int          fired_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: lanes are bounded queues, output is a one-word slot.
  always @(posedge clk) begin : model
    int          pre [NL];
    int          g;
    int          l;
    logic [31:0] w;
    cyc++;
    if (rst) begin
      for (int k = 0; k < NL; k++) mq[k].delete();
      m_vld = 1'b0;
      m_word = '0;
      m_lane = '0;
      m_rr  = 0;
      m_ovf = '0;
      sb.delete();
    end else begin
      for (int k = 0; k < NL; k++) pre[k] = mq[k].size();
      g = -1;
      if (!m_vld || m_tready) begin
        for (int i = 0; i < NL; i++) begin
          l = (m_rr + i) % NL;
          if (g < 0 && pre[l] > 0) g = l;
        end
      end
      if (m_vld && m_tready) m_vld = 1'b0;
      if (g >= 0) begin
        w      = mq[g].pop_front();
        m_vld  = 1'b1;
        m_word = w;
        m_lane = g[2:0];
        m_rr   = (g + 1) % NL;
        sb.push_back({g[2:0], w});
      end
      if (overflow_clr) m_ovf = '0;
      for (int k = 0; k < NL; k++) begin
        w = cin_command[32*k +: 32];
        if (cin_valid[k] && lane_enable[k] && !(drop_train && w == TRAIN)) begin
          if (pre[k] < DEPTH) mq[k].push_back(w);
          else m_ovf[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [34:0] e;
    chk("tvalid", {31'd0, m_tvalid}, {31'd0, m_vld});
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_tvalid) begin
      chk("tdata_hold", m_tdata, m_word);
      chk("tuser_hold", 32'(m_tuser), 32'(m_lane));
    end
    if (m_tvalid && m_tready && !rst) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got word %h lane %0d, expected no output", m_tdata, m_tuser);
      end else begin
        e = sb.pop_front();
        chk("sb_data", m_tdata, e[31:0]);
        chk("sb_lane", 32'(m_tuser), 32'(e[34:32]));
      end
      fired_words.push_back(m_tdata);
      fired_lanes.push_back(m_tuser);
      fired_cyc.push_back(cyc);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle();
    cin_valid    = '0;
    overflow_clr = 1'b0;
  endtask

  task automatic put(input int lane, input logic [31:0] w);
    cin_command[32*lane +: 32] = w;
    cin_valid[lane] = 1'b1;
  endtask

  task automatic clear_fired();
    fired_words.delete();
    fired_lanes.delete();
    fired_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cin_command  = '0;
    cin_valid    = '0;
    lane_enable  = '1;
    drop_train   = 1'b0;
    m_tready     = 1'b1;
    overflow_clr = 1'b0;
    run(3);

    // Reset state while rst is held
    @(negedge clk);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    cycle();
    rst = 1'b0;
    run(2);

    // Single word latency: input cycle N, output valid in cycle N+2
    put(3, 32'h12345678);
    @(negedge clk);
    chk("lat_n", {31'd0, m_tvalid}, 32'd0);
    cycle();
    idle();
    @(negedge clk);
    chk("lat_n1", {31'd0, m_tvalid}, 32'd0);
    cycle();
    @(negedge clk);
    chk("lat_n2_valid", {31'd0, m_tvalid}, 32'd1);
    chk("lat_n2_data", m_tdata, 32'h12345678);
    chk("lat_n2_user", 32'(m_tuser), 32'd3);
    run(3);

    // Round-robin bursts from rr=0
    do_reset();
    clear_fired();
    for (int k = 0; k < NL; k++) put(k, 32'h100 + k);
    cycle();
    idle();
    run(10);
    for (int k = 0; k < NL; k++) put(k, 32'h200 + k);
    cycle();
    idle();
    run(10);
    chk("rr_count", fired_lanes.size(), 32'd14);
    for (int i = 0; i < fired_lanes.size() && i < 14; i++)
      chk("rr_order", 32'(fired_lanes[i]), i % NL);
    for (int i = 1; i < fired_cyc.size() && i < NL; i++)
      chk("rr_back_to_back", fired_cyc[i] - fired_cyc[0], i);

    // Overflow with tready low: 5 words retained, 6th dropped
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(1, 32'h300 + i);
      cycle();
    end
    idle();
    @(negedge clk);
    chk("ovf_lane1", 32'(overflow[1]), 32'd1);
    clear_fired();
    cycle();
    m_tready = 1'b1;
    run(10);
    chk("ovf_drain_count", fired_words.size(), 32'd5);
    for (int i = 0; i < fired_words.size() && i < 5; i++)
      chk("ovf_drain_word", fired_words[i], 32'h300 + i);

    // Training-word filter on and off
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      drop_train = (pass == 0);
      clear_fired();
      put(0, TRAIN); cycle();
      put(0, 32'h1); cycle();
      put(0, TRAIN); cycle();
      idle();
      run(6);
      chk("train_count", fired_words.size(), (pass == 0) ? 32'd1 : 32'd3);
      if (pass == 0 && fired_words.size() > 0) chk("train_kept", fired_words[0], 32'h1);
    end
    drop_train = 1'b0;

    // Clear coincident with a new overflow, then clear alone
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(2, 32'h400 + i);
      cycle();
    end
    put(2, 32'h4ff);
    overflow_clr = 1'b1;
    cycle();
    idle();
    @(negedge clk);
    chk("clr_set_wins", 32'(overflow[2]), 32'd1);
    cycle();
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone", 32'(overflow[2]), 32'd0);
    m_tready = 1'b1;
    run(10);

    // Reset mid-transfer discards queued words
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(5, 32'h500 + i);
      cycle();
    end
    idle();
    cycle();
    @(negedge clk);
    chk("mid_rst_valid_before", {31'd0, m_tvalid}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid_after", {31'd0, m_tvalid}, 32'd0);
    clear_fired();
    m_tready = 1'b1;
    run(10);
    chk("mid_rst_no_replay", fired_words.size(), 32'd0);

    // Randomized soak against the model
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NL; k++)
        cin_command[32*k +: 32] = ($urandom_range(3) == 0) ? TRAIN : $urandom;
      cin_valid    = NL'($urandom);
      lane_enable  = ($urandom_range(9) == 0) ? NL'($urandom) : '1;
      drop_train   = 1'($urandom_range(1));
      m_tready     = ((c / 200) % 2 == 1) ? ($urandom_range(9) < 8) : ($urandom_range(9) < 4);
      overflow_clr = ($urandom_range(19) == 0);
      rst          = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    m_tready = 1'b1;
    run(40);
    chk("soak_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/turfio_cin_merge.md
TURFIO_CIN_MERGE -- requirements
Module: turfio_cin_merge

Interface
REQ-001 Parameter TRAIN_VALUE, default 32'hA55A6996: training word matched by the drop filter.
REQ-002 Parameter NUM_LANE, default 7: number of CIN lanes in one port.
REQ-003 Parameter FIFO_DEPTH, default 4: per-lane FIFO depth in words; power of 2, at least 2.
REQ-004 clk_i  in  1  interface clock (ifclk of the port's bank); all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 cin_command_i  in  32*NUM_LANE  per-lane command words, lane k at bits [32k +: 32].
REQ-007 cin_valid_i  in  NUM_LANE  lane k word valid this cycle.
REQ-008 lane_enable_i  in  NUM_LANE  lane k accepted when 1.
REQ-009 drop_train_i  in  1  when 1, words equal to TRAIN_VALUE are discarded.
REQ-010 m_tdata_o  out  32  merged output word.
REQ-011 m_tuser_o  out  3  source lane index of m_tdata_o.
REQ-012 m_tvalid_o  out  1  output word valid.
REQ-013 m_tready_i  in  1  downstream accepts the word when m_tvalid_o and m_tready_i are both 1.
REQ-014 overflow_o  out  NUM_LANE  sticky per-lane overflow flag.
REQ-015 overflow_clr_i  in  1  clears all overflow flags.

Function
REQ-016 Lane k write qualifier: cin_valid_i[k] & lane_enable_i[k] & !(drop_train_i & word==TRAIN_VALUE).
REQ-017 A qualified word is written to lane k FIFO only if the FIFO is not full at the start of the cycle; no same-cycle pass-through on full.
REQ-018 A qualified word arriving at a full FIFO is discarded and sets overflow_o[k] on the next edge.
REQ-019 If overflow_clr_i and a new overflow coincide, the flag is set (set wins).
REQ-020 Disabled or filtered words do not set overflow.
REQ-021 Clearing lane_enable_i[k] does not flush lane k; words already stored drain normally.
REQ-022 Output stage is a single register: it loads when empty or when its word is consumed in the same cycle; m_tdata_o/m_tuser_o are held stable while m_tvalid_o=1 and m_tready_i=0.
REQ-023 Arbiter: round-robin over non-empty FIFOs, searching from pointer rr upward and wrapping at NUM_LANE-1 to 0; after a grant to lane g, rr becomes (g+1) mod NUM_LANE.
REQ-024 rr is unchanged in cycles with no grant.
REQ-025 Latency: word valid at input in cycle N, with an empty FIFO, idle output and no contention, appears with m_tvalid_o=1 in cycle N+2.
REQ-026 Sustained throughput is one word per cycle while m_tready_i=1.
REQ-027 Per-lane word order is preserved; no word is duplicated or lost except per REQ-016/REQ-018.
REQ-028 FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and LSBs equal.

Reset
REQ-029 While rst_i=1: all FIFOs empty, rr=0, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, overflow_o=0.
REQ-030 Reset asserted mid-transfer discards all stored and pending words; there is no post-reset replay.
REQ-031 Inputs are ignored in any cycle with rst_i=1; the first write is possible in the first cycle after deassertion.

Structure
REQ-032 TRAIN_VALUE default and the NUM_LANE constant are defined in the shared package turfio_pkg.
REQ-033 The per-lane FIFO is a sub-module, turfio_lane_fifo (write, read, empty, full), instantiated NUM_LANE times in a generate loop.
REQ-034 Arbiter, output register and overflow flags reside in turfio_cin_merge.

Verification
REQ-035 Single word 32'h12345678 on lane 3 in cycle 10, tready=1 -> m_tvalid_o=1 in cycle 12 with tdata=32'h12345678, tuser=3.
REQ-036 All 7 lanes valid in one cycle, tready=1 -> outputs in tuser order 0,1,2,3,4,5,6 in consecutive cycles; a second burst then continues from lane 0.
REQ-037 tready=0, 6 words into lane 1 (FIFO_DEPTH=4) -> 4 stored (one moves to the output register, so 5 total retained), overflow_o[1]=1; tready=1 -> exactly 5 words out, in order.
REQ-038 drop_train_i=1, lane 0 sends A55A6996, 00000001, A55A6996 -> only 00000001 out; with drop_train_i=0 all 3 out.
REQ-039 overflow_clr_i coincident with a new lane 2 overflow -> overflow_o[2] remains 1; clear alone -> 0.
REQ-040 rst_i pulsed with 3 words queued and m_tvalid_o=1 -> next cycle m_tvalid_o=0, no queued word is ever output.
